// File: rtl/sptag_alloc_pkg.sv
// Shared widths for the speculative-tag allocator.
package sptag_alloc_pkg;

  localparam int unsigned SPTAG_WIDTH   = 5;
  localparam int unsigned SPDEPTH_WIDTH = $clog2(SPTAG_WIDTH) + 1;

endpackage

// File: rtl/sptag_alloc_if.sv
// Dispatch/resolve bus between the rename stage and the speculative-tag allocator.
interface sptag_alloc_if
  import sptag_alloc_pkg::*;
#(
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned SPTAG_W    = SPTAG_WIDTH
);
  localparam int unsigned DW = $clog2(SPTAG_W) + 1;

  logic                          i_dispatch;
  logic [DISPATCH_W-1:0]         i_valid;
  logic [DISPATCH_W-1:0]         i_is_br;
  logic                          i_prsuc;
  logic                          i_prmiss;
  logic                          o_allocable;
  logic [DISPATCH_W-1:0]         o_inst_sp;
  logic [DISPATCH_W*SPTAG_W-1:0] o_inst_sptag;
  logic [DW-1:0]                 o_spdepth;
  logic [SPTAG_W-1:0]            o_ctag;
  logic [SPTAG_W-1:0]            o_sptag;
  logic                          o_underflow;

  modport master (
    output i_dispatch, i_valid, i_is_br, i_prsuc, i_prmiss,
    input  o_allocable, o_inst_sp, o_inst_sptag, o_spdepth, o_ctag, o_sptag, o_underflow
  );

  modport slave (
    input  i_dispatch, i_valid, i_is_br, i_prsuc, i_prmiss,
    output o_allocable, o_inst_sp, o_inst_sptag, o_spdepth, o_ctag, o_sptag, o_underflow
  );

endinterface

// File: rtl/sptag_rotn.sv
// One-hot left rotate by a small count (0..MAXN).
module sptag_rotn #(
  parameter int unsigned W    = 5,
  parameter int unsigned MAXN = 2,
  parameter int unsigned NW   = 2
) (
  input  logic [W-1:0]  x_i,
  input  logic [NW-1:0] n_i,
  output logic [W-1:0]  y_o
);

  logic [W-1:0] acc;

  always_comb begin
    acc = x_i;
    for (int unsigned i = 0; i < MAXN; i++) begin
      if (NW'(i) < n_i) acc = {acc[W-2:0], acc[W-1]};
    end
    y_o = acc;
  end

endmodule

// File: rtl/sptag_alloc.sv
// Assigns one-hot speculative-region tags to dispatched slots and tracks
// outstanding branch depth, committed tag and youngest speculative tag.
module sptag_alloc
  import sptag_alloc_pkg::*;
#(
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned SPTAG_W    = SPTAG_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  sptag_alloc_if.slave bus
);

  localparam int unsigned MAX_DEPTH = SPTAG_W - 1;
  localparam int unsigned DW        = $clog2(SPTAG_W) + 1;
  localparam int unsigned SW        = DW + 1;
  localparam int unsigned NW        = $clog2(DISPATCH_W + 1);

  logic [DW-1:0]      spdepth_q, spdepth_d;
  logic [SPTAG_W-1:0] sptag_q, sptag_d;
  logic [SPTAG_W-1:0] ctag_q, ctag_d;
  logic               underflow_q, underflow_d;

  logic [NW-1:0]      nb_k [DISPATCH_W];
  logic [NW-1:0]      nb_all;
  logic [SPTAG_W-1:0] slot_tag [DISPATCH_W];
  logic [SPTAG_W-1:0] sptag_adv;
  logic [SPTAG_W-1:0] ctag_rot;
  logic [SW-1:0]      need_c;
  logic               allocable_c;
  logic               fire_c;

  // Running count of older branches in the group (prefix sum).
  always_comb begin
    logic [NW-1:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      nb_k[k] = acc;
      acc     = acc + NW'(bus.i_valid[k] & bus.i_is_br[k]);
    end
    nb_all = acc;
  end

  for (genvar k = 0; k < DISPATCH_W; k++) begin : g_slot
    sptag_rotn #(.W(SPTAG_W), .MAXN(DISPATCH_W), .NW(NW)) u_rot (
      .x_i (sptag_q),
      .n_i (nb_k[k]),
      .y_o (slot_tag[k])
    );
  end

  sptag_rotn #(.W(SPTAG_W), .MAXN(DISPATCH_W), .NW(NW)) u_next (
    .x_i (sptag_q),
    .n_i (nb_all),
    .y_o (sptag_adv)
  );

  assign ctag_rot    = {ctag_q[SPTAG_W-2:0], ctag_q[SPTAG_W-1]};
  // A wrapped (negative) sum lands far above MAX_DEPTH and reads as not allocable.
  assign need_c      = SW'(spdepth_q) + SW'(nb_all) - SW'(bus.i_prsuc);
  assign allocable_c = (need_c <= SW'(MAX_DEPTH));
  assign fire_c      = bus.i_dispatch & allocable_c & ~bus.i_prmiss;

  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      bus.o_inst_sptag[k*SPTAG_W +: SPTAG_W] = slot_tag[k];
      bus.o_inst_sp[k] = ((SW'(spdepth_q) + SW'(nb_k[k])) != '0);
    end
  end

  // Misprediction wins over success; resolving with nothing outstanding only flags an error.
  always_comb begin
    spdepth_d   = spdepth_q;
    sptag_d     = sptag_q;
    ctag_d      = ctag_q;
    underflow_d = underflow_q;
    if (bus.i_prmiss) begin
      if (spdepth_q == '0) begin
        underflow_d = 1'b1;
      end else begin
        spdepth_d = '0;
        ctag_d    = ctag_rot;
        sptag_d   = ctag_rot;
      end
    end else if (bus.i_prsuc && (spdepth_q == '0)) begin
      underflow_d = 1'b1;
    end else begin
      if (fire_c) begin
        sptag_d   = sptag_adv;
        spdepth_d = spdepth_d + DW'(nb_all);
      end
      if (bus.i_prsuc) begin
        ctag_d    = ctag_rot;
        spdepth_d = spdepth_d - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spdepth_q   <= '0;
      sptag_q     <= SPTAG_W'(1);
      ctag_q      <= SPTAG_W'(1);
      underflow_q <= 1'b0;
    end else begin
      spdepth_q   <= spdepth_d;
      sptag_q     <= sptag_d;
      ctag_q      <= ctag_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.o_allocable = allocable_c;
  assign bus.o_spdepth   = spdepth_q;
  assign bus.o_ctag      = ctag_q;
  assign bus.o_sptag     = sptag_q;
  assign bus.o_underflow = underflow_q;

endmodule
